// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state encodings shared by the
// multi-cycle execute-stage ALU and its divider.
package alu_pkg;

    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_SUB = 6'd1;
    localparam logic [5:0] ALU_MUL = 6'd2;
    localparam logic [5:0] ALU_DIV = 6'd3;
    localparam logic [5:0] ALU_SLL = 6'd4;
    localparam logic [5:0] ALU_SRL = 6'd5;
    localparam logic [5:0] ALU_SLT = 6'd6;
    localparam logic [5:0] ALU_AND = 6'd7;
    localparam logic [5:0] ALU_OR  = 6'd8;
    localparam logic [5:0] ALU_XOR = 6'd9;
    localparam logic [5:0] ALU_NOR = 6'd10;
    localparam logic [5:0] ALU_SRA = 6'd11;
    localparam logic [5:0] ALU_LUI = 6'd12;
    localparam logic [5:0] ALU_REM = 6'd13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative unsigned restoring divider, one quotient bit
// per cycle; operands are magnitudes, signs are handled by the caller.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Partial remainder stays below the divisor, so the shifted value
    // fits WIDTH bits and the difference is exact modulo 2^WIDTH.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = w_shift >= {1'b0, r_dvs};
    assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

    // done marks the final iteration; results are valid the next cycle.
    assign done      = r_busy & (r_cnt == LAST);
    assign quotient  = r_quo;
    assign remainder = r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_quo  <= dividend;
            r_rem  <= '0;
            r_dvs  <= divisor;
        end else if (r_busy) begin
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready handshakes.
// Define ALU_REM_EN to add signed REM (op 13) on the shared divider.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         operation,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               neg
);

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);

    alu_state_e       r_state;
    alu_state_e       w_next;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_take;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_is_rem;
    logic             w_div_op;
    logic             w_div_spec;
    logic             w_div_start;
    logic             w_div_done;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_fix_q;
    logic [WIDTH-1:0] w_fix_r;

    assign w_in_ready = (r_state == ST_IDLE) & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & w_in_ready;
    assign w_take     = r_out_valid & out_ready;

    assign w_is_mul = (operation == ALU_MUL);
    assign w_is_div = (operation == ALU_DIV);
`ifdef ALU_REM_EN
    assign w_is_rem = (operation == ALU_REM);
`else
    assign w_is_rem = 1'b0;
`endif
    assign w_div_op    = w_is_div | w_is_rem;
    // Divide by zero and MIN / -1 resolve in one cycle without iterating.
    assign w_div_spec  = (op2 == '0) | ((op1 == MIN) & (op2 == '1));
    assign w_div_start = w_accept & w_div_op & ~w_div_spec;

    assign w_abs1 = op1[WIDTH-1] ? -op1 : op1;
    assign w_abs2 = op2[WIDTH-1] ? -op2 : op2;

    alu_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .dividend (w_abs1),
        .divisor  (w_abs2),
        .done     (w_div_done),
        .quotient (w_quo),
        .remainder(w_rem)
    );

    assign w_fix_q    = r_neg_q ? -w_quo : w_quo;
    assign w_fix_r    = r_neg_r ? -w_rem : w_rem;
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_single = '0;
        case (operation)
            ALU_ADD: w_single = op1 + op2;
            ALU_SUB: w_single = op1 - op2;
            ALU_DIV: w_single = (op2 == '0) ? '1 : MIN;
            ALU_SLL: w_single = op2 << shamt;
            ALU_SRL: w_single = op2 >> shamt;
            ALU_SLT: w_single = {{(WIDTH-1){1'b0}},
                                 $signed(op1) < $signed(op2)};
            ALU_AND: w_single = op1 & op2;
            ALU_OR:  w_single = op1 | op2;
            ALU_XOR: w_single = op1 ^ op2;
            ALU_NOR: w_single = ~(op1 | op2);
            ALU_SRA: w_single = $signed(op2) >>> shamt;
            ALU_LUI: w_single = op2 << (WIDTH / 2);
            default: w_single = '0;
        endcase
        if (w_is_rem) begin
            w_single = (op2 == '0) ? op1 : '0;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = w_single;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_next = ST_MUL;
                    end else if (w_div_op & ~w_div_spec) begin
                        w_next = ST_DIV;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (r_cnt == MUL_LAST) begin
                    w_next     = ST_IDLE;
                    w_load     = 1'b1;
                    w_load_val = w_acc_next;
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_next     = ST_IDLE;
                w_load     = 1'b1;
                w_load_val = r_is_rem ? w_fix_r : w_fix_q;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_load_val;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept & w_is_mul) begin
            r_mcand  <= op1;
            r_mplier <= op2;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == ST_MUL) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (w_div_start) begin
            r_neg_q  <= op1[WIDTH-1] ^ op2[WIDTH-1];
            r_neg_r  <= op1[WIDTH-1];
            r_is_rem <= w_is_rem;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = (r_result == '0);
    assign neg       = r_result[WIDTH-1];

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with a queue scoreboard and an
// independent output monitor for alu_mc at WIDTH=32.
module tb_alu_mc;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          pre;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  operation;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        neg;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;
    int   last_acc = 0;
    int   vstart = 0;
    bit   prev_v = 0;
    bit   prev_t = 0;

    alu_mc #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .operation(operation),
        .op1      (op1),
        .op2      (op2),
        .shamt    (shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 0;
            prev_t = 0;
        end else begin
            if (out_valid && (!prev_v || prev_t)) vstart = cyc;
            prev_v = out_valid;
            prev_t = out_valid && out_ready;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_out: got %h, want none", result);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("latency", 32'(vstart - e.pre), 32'(e.lat));
                    chk("zero", 32'(zero), 32'(e.res == 32'h0));
                    chk("neg", 32'(neg), 32'(e.res[31]));
                end
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] res, input int lat,
                         input bit push);
        int   w;
        exp_t e;
        @(negedge clk);
        operation = op;
        op1       = a;
        op2       = b;
        shamt     = sh;
        in_valid  = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_tot++;
            $display("FAIL issue_timeout op %0d: in_ready %b, want 1", op, in_ready);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.res = res;
            e.lat = lat;
            e.pre = cyc;
            sb.push_back(e);
        end
        last_acc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad;
        int          t0;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] x;
        logic [5:0]  op;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operation = '0;
        op1       = '0;
        op2       = '0;
        shamt     = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_neg", 32'(neg), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(ALU_ADD, 32'd2, 32'd1, 5'd0, 32'd3, 1, 1);
        issue(ALU_SUB, 32'd0, 32'd1, 5'd0, 32'hffffffff, 1, 1);
        issue(ALU_ADD, 32'hffffffff, 32'd1, 5'd0, 32'h0, 1, 1);

        issue(ALU_MUL, 32'd3, 32'd2, 5'd0, 32'd6, 33, 1);
        bad = 0;
        repeat (32) begin
            @(negedge clk);
            if (in_ready) bad++;
        end
        chk("mul_in_ready_busy", 32'(bad), 32'd0);
        issue(ALU_MUL, 32'hfffffffd, 32'd5, 5'd0, 32'hfffffff1, 33, 1);

        issue(ALU_DIV, 32'hfffffc18, 32'd4, 5'd0, 32'hffffff06, 34, 1);
        issue(ALU_DIV, 32'd7, 32'hfffffffe, 5'd0, 32'hfffffffd, 34, 1);
        issue(ALU_DIV, 32'd7, 32'd0, 5'd0, 32'hffffffff, 1, 1);
        issue(ALU_DIV, 32'h80000000, 32'hffffffff, 5'd0, 32'h80000000, 1, 1);

        issue(ALU_SRA, 32'hffffe808, 32'hffffe808, 5'd8, 32'hffffffe8, 1, 1);
        issue(ALU_SLL, 32'h000000f1, 32'h000000f1, 5'd4, 32'h00000f10, 1, 1);
        issue(ALU_SRL, 32'h80000000, 32'h80000000, 5'd31, 32'h1, 1, 1);
        issue(ALU_SLT, 32'hfffffc18, 32'd4, 5'd0, 32'h1, 1, 1);
        issue(ALU_SLT, 32'd4, 32'hfffffc18, 5'd0, 32'h0, 1, 1);
        issue(ALU_AND, 32'hf0f0ff00, 32'h0ff0f0f0, 5'd0, 32'h00f0f000, 1, 1);
        issue(ALU_OR,  32'hf0f0ff00, 32'h0ff0f0f0, 5'd0, 32'hfff0fff0, 1, 1);
        issue(ALU_XOR, 32'hf0f0ff00, 32'h0ff0f0f0, 5'd0, 32'hff000ff0, 1, 1);
        issue(ALU_NOR, 32'h0, 32'h0, 5'd0, 32'hffffffff, 1, 1);
        issue(ALU_LUI, 32'h0, 32'h1, 5'd0, 32'h00010000, 1, 1);
`ifdef ALU_REM_EN
        issue(ALU_REM, 32'hfffffff9, 32'd2, 5'd0, 32'hffffffff, 34, 1);
        issue(ALU_REM, 32'd7, 32'd0, 5'd0, 32'd7, 1, 1);
`else
        issue(6'd13, 32'd5, 32'd3, 5'd0, 32'h0, 1, 1);
`endif
        issue(6'd63, 32'd5, 32'd3, 5'd0, 32'h0, 1, 1);
        drain("drain_directed");

        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(ALU_ADD, 32'd5, 32'd6, 5'd0, 32'd11, 1, 1);
        @(negedge clk);
        operation = ALU_ADD;
        op1       = 32'd1;
        op2       = 32'd1;
        in_valid  = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_result_held", result, 32'd11);
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain("drain_backpressure");

        for (int i = 0; i < 1000; i++) begin
            a = 32'(i) * 32'd13;
            b = 32'h100 - 32'(i);
            if (i % 3 == 0) begin
                op = ALU_ADD;
                x  = a + b;
            end else if (i % 3 == 1) begin
                op = ALU_XOR;
                x  = a ^ b;
            end else begin
                op = ALU_AND;
                x  = a & b;
            end
            issue(op, a, b, 5'd0, x, 1, 1);
            if (i == 0) t0 = last_acc;
        end
        chk("stream_rate", 32'(last_acc - t0), 32'd999);
        drain("drain_stream");

        issue(ALU_DIV, 32'd100, 32'd3, 5'd0, 32'd0, 0, 0);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", result, 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(ALU_ADD, 32'd20, 32'd22, 5'd0, 32'd42, 1, 1);
        drain("drain_after_abort");

        repeat (40) @(negedge clk);
        chk("no_stray_out", 32'(out_valid), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
